// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned PC_W_DEF         = 12;
  localparam int unsigned INSTR_W_DEF      = 16;
  localparam logic [11:0] RESET_ADDR_DEF   = 12'h000;
  localparam logic [11:0] HANDLER_ADDR_DEF = 12'hFF0;
  localparam logic [15:0] NOP_DEF          = 16'h0000;

  // Instruction field positions used by decode.
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned FUNC_MSB = 7;
  localparam int unsigned FUNC_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register: flush forces a bubble, write enable holds, otherwise
// loads the delivered instruction or a bubble.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned         PC_W    = PC_W_DEF,
  parameter int unsigned         INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0]  NOP     = INSTR_W'(NOP_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_en,
  input  logic               flush,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc1,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc1,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc1_q, pc1_d;
  logic               valid_q, valid_d;

  // Next IF/ID contents: flush beats hold, hold beats load/bubble.
  always_comb begin
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (write_en) begin
      if (load_valid) begin
        instr_d = load_instr;
        pc1_d   = load_pc1;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP;
        valid_d = 1'b0;
      end
    end
  end

  // IF/ID register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc1   = pc1_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the wait-state memory handshake,
// applies redirects and stalls, and feeds the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned        PC_W         = PC_W_DEF,
  parameter int unsigned        INSTR_W      = INSTR_W_DEF,
  parameter logic [PC_W-1:0]    RESET_ADDR   = PC_W'(RESET_ADDR_DEF),
  parameter logic [PC_W-1:0]    HANDLER_ADDR = PC_W'(HANDLER_ADDR_DEF),
  parameter logic [INSTR_W-1:0] NOP          = INSTR_W'(NOP_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic               ifid_write,
  input  logic               flush,
  input  logic               branch,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               handler,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc1,
  output logic               ifid_valid,
  output logic [PC_W-1:0]    pc
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    redir_pc_q, redir_pc_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic [PC_W-1:0]    target, pc_inc;
  logic [INSTR_W-1:0] deliver_instr;
  logic               accept, redirect, deliver;

  assign accept   = pc_write & ifid_write;
  assign redirect = handler | jump | branch;
  assign pc_inc   = pc_q + PC_W'(1);

  // Redirect target by priority: handler, then jump, then branch.
  always_comb begin
    target = branch_target;
    if (handler)   target = HANDLER_ADDR;
    else if (jump) target = jump_target;
  end

  // Fetch FSM: next state, next PC, buffer/redirect capture and delivery.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    redir_pc_d    = redir_pc_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d = target;
          end else if (accept) begin
            deliver = 1'b1;
            pc_d    = pc_inc;
          end else begin
            buf_d   = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          redir_pc_d = target;
          state_d    = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        deliver_instr = buf_q;
        if (redirect) begin
          pc_d    = target;
          state_d = ST_FETCH;
        end else if (accept) begin
          deliver = 1'b1;
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (redirect) redir_pc_d = target;
        // The in-flight request must complete before the PC may move.
        if (imem_ready) begin
          pc_d    = redirect ? target : redir_pc_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Fetch state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_ADDR;
      redir_pc_q <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      buf_q      <= buf_d;
    end
  end

  assign imem_req  = ~rst & (state_q != ST_HOLD);
  assign imem_addr = pc_q;
  assign pc        = pc_q;

  // Delivered instructions always belong to the unadvanced pc, so PC+1 is pc_inc.
  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .NOP     (NOP)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .write_en   (ifid_write),
    .flush      (flush),
    .load_valid (deliver),
    .load_instr (deliver_instr),
    .load_pc1   (pc_inc),
    .instr      (ifid_instr),
    .pc1        (ifid_pc1),
    .valid      (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage using a scoreboard of expected IF/ID loads.
module tb_fetch_stage;

  localparam logic [11:0] HANDLER = 12'hFF0;
  localparam logic [15:0] NOPW    = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, pc_write, ifid_write, flush, branch, jump, handler;
  logic [11:0] branch_target, jump_target;
  logic        imem_req, imem_ready, ifid_valid;
  logic [11:0] imem_addr, ifid_pc1, pc;
  logic [15:0] imem_rdata, ifid_instr;

  typedef struct packed {
    logic [15:0] instr;
    logic [11:0] pc1;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    return {4'h9, a ^ 12'h5A5};
  endfunction

  assign imem_rdata = imem_req ? mem_word(imem_addr) : 16'hDEAD;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .flush         (flush),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .handler       (handler),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .ifid_instr    (ifid_instr),
    .ifid_pc1      (ifid_pc1),
    .ifid_valid    (ifid_valid),
    .pc            (pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [11:0] a);
    exp_t e;
    e.instr = mem_word(a);
    e.pc1   = a + 12'd1;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_write = 1'b1; ifid_write = 1'b1; flush = 1'b0;
    branch = 1'b0; jump = 1'b0; handler = 1'b0; imem_ready = 1'b0;
    branch_target = '0; jump_target = '0;
    step(); step();
    checks++; if (pc !== 12'h000) begin failures++; $display("FAIL rst_pc got=%h exp=000", pc); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ifid_valid); end
    checks++; if (ifid_instr !== NOPW) begin failures++; $display("FAIL rst_instr got=%h exp=%h", ifid_instr, NOPW); end
    checks++; if (ifid_pc1 !== 12'h000) begin failures++; $display("FAIL rst_pc1 got=%h exp=000", ifid_pc1); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
  endtask

  task automatic test_zero_wait();
    exp_t e;
    for (int i = 0; i < 4; i++) push_exp(12'(i));
    rst = 1'b0; imem_ready = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin failures++; $display("FAIL zw_first_req got=%b/%h exp=1/000", imem_req, imem_addr); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ifid_valid !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL zw_valid cyc=%0d got=%b exp=1 sb=%0d", i, ifid_valid, sb.size());
      end else begin
        e = sb.pop_front();
        checks++;
        if (ifid_instr !== e.instr || ifid_pc1 !== e.pc1) begin
          failures++; $display("FAIL zw_data cyc=%0d got=%h/%h exp=%h/%h", i, ifid_instr, ifid_pc1, e.instr, e.pc1);
        end
      end
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_wait_states();
    exp_t        e;
    logic [11:0] exp_addr = 12'h004;
    logic        rdy;
    for (int c = 0; c < 9; c++) begin
      imem_ready = ((c % 3) == 2); #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        failures++; $display("FAIL ws_addr cyc=%0d got=%b/%h exp=1/%h", c, imem_req, imem_addr, exp_addr);
      end
      rdy = imem_ready;
      if (rdy) push_exp(exp_addr);
      step();
      checks++;
      if (rdy) begin
        if (ifid_valid !== 1'b1 || sb.size() == 0) begin
          failures++; $display("FAIL ws_valid cyc=%0d got=%b exp=1", c, ifid_valid);
        end else begin
          e = sb.pop_front();
          if (ifid_instr !== e.instr || ifid_pc1 !== e.pc1) begin
            failures++; $display("FAIL ws_data cyc=%0d got=%h/%h exp=%h/%h", c, ifid_instr, ifid_pc1, e.instr, e.pc1);
          end
        end
        exp_addr = exp_addr + 12'd1;
      end else if (ifid_valid !== 1'b0) begin
        failures++; $display("FAIL ws_bubble cyc=%0d got=%b exp=0", c, ifid_valid);
      end
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_stall();
    exp_t e;
    jump = 1'b1; jump_target = 12'h004; imem_ready = 1'b1;
    step();
    jump = 1'b0;
    checks++; if (pc !== 12'h004 || ifid_valid !== 1'b0) begin failures++; $display("FAIL st_jump got=%h/%b exp=004/0", pc, ifid_valid); end
    push_exp(12'h004);
    step();
    checks++;
    if (ifid_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL st_pre_valid got=%b exp=1", ifid_valid);
    end else begin
      e = sb.pop_front();
      if (ifid_instr !== e.instr || ifid_pc1 !== e.pc1 || pc !== 12'h005) begin
        failures++; $display("FAIL st_pre_data got=%h/%h/%h exp=%h/%h/005", ifid_instr, ifid_pc1, pc, e.instr, e.pc1);
      end
    end
    pc_write = 1'b0; ifid_write = 1'b0;
    step();
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (imem_req !== 1'b0 || pc !== 12'h005) begin
        failures++; $display("FAIL st_hold k=%0d got=%b/%h exp=0/005", k, imem_req, pc);
      end
      checks++;
      if (ifid_valid !== 1'b1 || ifid_instr !== mem_word(12'h004) || ifid_pc1 !== 12'h005) begin
        failures++; $display("FAIL st_ifid_held k=%0d got=%b/%h/%h exp=1/%h/005", k, ifid_valid, ifid_instr, ifid_pc1, mem_word(12'h004));
      end
      if (k < 2) step();
    end
    pc_write = 1'b1; ifid_write = 1'b1;
    push_exp(12'h005);
    step();
    checks++;
    if (ifid_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL st_rel_valid got=%b exp=1", ifid_valid);
    end else begin
      e = sb.pop_front();
      if (ifid_instr !== e.instr || ifid_pc1 !== e.pc1) begin
        failures++; $display("FAIL st_rel_data got=%h/%h exp=%h/%h", ifid_instr, ifid_pc1, e.instr, e.pc1);
      end
    end
    checks++; if (pc !== 12'h006 || imem_req !== 1'b1) begin failures++; $display("FAIL st_rel_pc got=%h/%b exp=006/1", pc, imem_req); end
  endtask

  task automatic test_drain_redirect();
    exp_t e;
    jump = 1'b1; jump_target = 12'h008; imem_ready = 1'b1;
    step();
    jump = 1'b0; imem_ready = 1'b0;
    jump = 1'b1; jump_target = 12'h040;
    step();
    jump = 1'b0; branch = 1'b1; branch_target = 12'h020; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h008) begin failures++; $display("FAIL dr_addr1 got=%b/%h exp=1/008", imem_req, imem_addr); end
    step();
    branch = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h008) begin failures++; $display("FAIL dr_addr2 got=%b/%h exp=1/008", imem_req, imem_addr); end
    imem_ready = 1'b1;
    step();
    checks++; if (pc !== 12'h020 || imem_addr !== 12'h020) begin failures++; $display("FAIL dr_target got=%h/%h exp=020/020", pc, imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL dr_discard got=%b exp=0", ifid_valid); end
    handler = 1'b1; jump = 1'b1; jump_target = 12'h030;
    step();
    handler = 1'b0; jump = 1'b0;
    checks++; if (pc !== HANDLER || ifid_valid !== 1'b0) begin failures++; $display("FAIL dr_handler got=%h/%b exp=%h/0", pc, ifid_valid, HANDLER); end
    push_exp(HANDLER);
    step();
    checks++;
    if (ifid_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL dr_hfetch_valid got=%b exp=1", ifid_valid);
    end else begin
      e = sb.pop_front();
      if (ifid_instr !== e.instr || ifid_pc1 !== e.pc1) begin
        failures++; $display("FAIL dr_hfetch_data got=%h/%h exp=%h/%h", ifid_instr, ifid_pc1, e.instr, e.pc1);
      end
    end
    imem_ready = 1'b0; jump = 1'b1; jump_target = 12'h100;
    step();
    jump = 1'b0; branch = 1'b1; branch_target = 12'h200; imem_ready = 1'b1;
    step();
    branch = 1'b0;
    checks++; if (pc !== 12'h200 || ifid_valid !== 1'b0) begin failures++; $display("FAIL dr_same_cycle got=%h/%b exp=200/0", pc, ifid_valid); end
  endtask

  task automatic test_flush_wrap();
    exp_t e;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOPW) begin failures++; $display("FAIL fl_bubble got=%b/%h exp=0/%h", ifid_valid, ifid_instr, NOPW); end
    checks++; if (pc !== 12'h201) begin failures++; $display("FAIL fl_pc got=%h exp=201", pc); end
    jump = 1'b1; jump_target = 12'hFFF;
    step();
    jump = 1'b0;
    checks++; if (pc !== 12'hFFF) begin failures++; $display("FAIL wr_jump got=%h exp=fff", pc); end
    push_exp(12'hFFF);
    step();
    checks++;
    if (ifid_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL wr_valid got=%b exp=1", ifid_valid);
    end else begin
      e = sb.pop_front();
      if (ifid_instr !== e.instr || ifid_pc1 !== e.pc1) begin
        failures++; $display("FAIL wr_data got=%h/%h exp=%h/%h", ifid_instr, ifid_pc1, e.instr, e.pc1);
      end
    end
    checks++; if (pc !== 12'h000) begin failures++; $display("FAIL wr_pc got=%h exp=000", pc); end
    imem_ready = 1'b0;
  endtask

  task automatic test_reset_in_drain();
    exp_t e;
    jump = 1'b1; jump_target = 12'h055;
    step();
    jump = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin failures++; $display("FAIL rd_drain got=%b/%h exp=1/000", imem_req, imem_addr); end
    rst = 1'b1;
    step();
    checks++; if (pc !== 12'h000 || ifid_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rd_reset got=%h/%b/%b exp=000/0/0", pc, ifid_valid, imem_req); end
    rst = 1'b0; imem_ready = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin failures++; $display("FAIL rd_req got=%b/%h exp=1/000", imem_req, imem_addr); end
    push_exp(12'h000);
    step();
    checks++;
    if (ifid_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL rd_valid got=%b exp=1", ifid_valid);
    end else begin
      e = sb.pop_front();
      if (ifid_instr !== e.instr || ifid_pc1 !== e.pc1 || pc !== 12'h001) begin
        failures++; $display("FAIL rd_data got=%h/%h/%h exp=%h/%h/001", ifid_instr, ifid_pc1, pc, e.instr, e.pc1);
      end
    end
    imem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_drain_redirect();
    test_flush_wrap();
    test_reset_in_drain();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
